byte_fifo_wr_arb: RTL and testbench
===================================

Name: byte_fifo_wr_arb

Overview:
Round-robin, packet-locked arbiter that shares the write port of one byte_fifo between NUM_REQ requesters. Each requester sends variable-length beats of up to DATA_IN_BYTES_W bytes. The arbiter forwards one beat per cycle through a registered output stage, and only when the FIFO has guaranteed space. It sits directly in front of byte_fifo and drives input_data_valid, input_data and num_bytes_in; it receives num_bytes back for credit tracking.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_IN_BYTES_W, 16, max bytes per beat; must equal the byte_fifo setting
FIFO_BYTE_W, 32, byte_fifo capacity in bytes
NUM_BYTES_IN_W, 5, width of byte counts per beat (clog2(DATA_IN_BYTES_W+1))
ADD_W, 6, width of the FIFO occupancy count (clog2(FIFO_BYTE_W+1))
REQ_ID_W, 2, width of a requester index (clog2(NUM_REQ), minimum 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
sync_rst  in  1  synchronous clear; the same signal also drives the byte_fifo sync_rst
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester last beat of packet
req_bytes  in  NUM_REQ*NUM_BYTES_IN_W  per-requester byte count; requester i occupies slice i
req_data  in  NUM_REQ*DATA_IN_BYTES_W*8  per-requester data, little-endian bytes
req_ready  out  NUM_REQ  per-requester accept, combinational
fifo_num_bytes  in  ADD_W  byte_fifo num_bytes
fifo_in_valid  out  1  to byte_fifo input_data_valid, registered
fifo_in_data  out  DATA_IN_BYTES_W*8  to byte_fifo input_data, registered
fifo_num_bytes_in  out  NUM_BYTES_IN_W  to byte_fifo num_bytes_in, registered
fifo_in_id  out  REQ_ID_W  source requester of the current output beat, registered
err_len  out  1  sticky: a beat was accepted with req_bytes > DATA_IN_BYTES_W

Behaviour:
- Reset (rst high, async) clears: all registered outputs to 0, err_len to 0, state to IDLE, rr_ptr to 0.
- sync_rst has the same effect on the next clock edge. While sync_rst is high, req_ready is all 0.
- Transfer rule: a beat on requester i transfers when req_valid[i] & req_ready[i]. Requesters hold data, bytes and last stable until the transfer.
- Free space: free = FIFO_BYTE_W - fifo_num_bytes - (fifo_in_valid ? fifo_num_bytes_in : 0).
  - Compute at ADD_W+1 bits; a negative result counts as 0.
  - FIFO drain in the current cycle is ignored, so the estimate is conservative.
- Fit condition: fits = (req_bytes[g] <= free), where g is the current grant.
- req_ready[i] = (i == g) & grant_active & fits & ~sync_rst. All other requesters see ready 0.
- State IDLE:
  - g is the first valid requester at or after rr_ptr, searching with wrap-around; grant_active = |req_valid.
  - Transfer with last: remain IDLE, rr_ptr <= (g+1) mod NUM_REQ.
  - Transfer without last: go to LOCKED, lock_id <= g.
  - Valid but no transfer (no fit): go to LOCKED, lock_id <= g. The winner is held, so it cannot be starved.
- State LOCKED:
  - g = lock_id; grant_active = req_valid[lock_id].
  - Transfer with last: go to IDLE, rr_ptr <= (lock_id+1) mod NUM_REQ.
  - Other requesters are ignored until that last beat transfers.
- Output stage, one-cycle latency, one beat per cycle:
  - On a transfer with 0 < req_bytes <= DATA_IN_BYTES_W: fifo_in_valid <= 1, fifo_in_data <= req_data[g], fifo_num_bytes_in <= req_bytes[g], fifo_in_id <= g.
  - Otherwise fifo_in_valid <= 0; data, bytes and id hold their values.
  - Back-to-back beats from the same requester are allowed every cycle while they fit.
- Zero-byte beat: transfers normally, including its last handling, but produces no output beat.
- Oversize beat (req_bytes > DATA_IN_BYTES_W): transfers, is dropped (no output beat), sets err_len. err_len clears only on rst or sync_rst.
- A requester deasserting req_valid while LOCKED stalls the arbiter in LOCKED; this is legal.

Decomposition:
- Package byte_fifo_pkg holds:
  - the state enum {IDLE, LOCKED};
  - a clog2-style width function used to derive NUM_BYTES_IN_W, ADD_W and REQ_ID_W;
  - slice-index helper constants.
- Sub-module byte_fifo_rr_pick (combinational): inputs req_valid and rr_ptr; outputs grant index and any_valid. It is reused by other byte_fifo users.

Test Plan:
1. Fit and stall: fifo_num_bytes=0, no drain; req0 sends 4 beats of 16 bytes, last on the 4th -> beat1 accepted, beat2 accepted (free=16), beat3 stalls with req_ready[0]=0 while fifo_num_bytes=32; releasing fifo_num_bytes to 16 accepts beat3.
2. Round-robin: rr_ptr=0; req0 and req2 each send a single last beat of 8 bytes -> fifo_in_id is 0 then 2 on consecutive cycles, rr_ptr=3; req0 again -> wraps, granted, rr_ptr=1.
3. Lock: req1 sends 3 beats; req0 asserts during beat 2 -> req_ready[0]=0 until req1's last transfers; req0 is granted the next cycle.
4. Full boundary: fifo_num_bytes=30, fifo_in_valid=0, req3 offers 4 bytes -> ready 0, state LOCKED on req3; fifo_num_bytes=28 -> accepted, fifo_num_bytes_in=4 one cycle later.
5. Zero-byte and oversize beats: req2 last beat with req_bytes=0 -> transfers, fifo_in_valid stays 0, grant released. Next beat with req_bytes=17 -> dropped, err_len=1 until sync_rst.
6. Reset mid-packet: sync_rst while LOCKED on req1 -> next cycle IDLE, rr_ptr=0, fifo_in_valid=0, err_len=0; async rst pulse mid-cycle -> outputs 0 immediately.

Source files
------------

// File: rtl/byte_fifo_pkg.sv
// byte_fifo_pkg: shared types, width helper and constants for byte_fifo users
package byte_fifo_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  localparam int BYTE_W = 8;
  function automatic int clog2w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/byte_fifo_wr_arb_if.sv
// byte_fifo_wr_arb_if: requester beats in, byte_fifo write port out
interface byte_fifo_wr_arb_if import byte_fifo_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_IN_BYTES_W = 16,
  parameter int FIFO_BYTE_W = 32,
  parameter int NUM_BYTES_IN_W = clog2w(DATA_IN_BYTES_W + 1),
  parameter int ADD_W = clog2w(FIFO_BYTE_W + 1),
  parameter int REQ_ID_W = clog2w(NUM_REQ)
) ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ*NUM_BYTES_IN_W-1:0] req_bytes;
  logic [NUM_REQ*DATA_IN_BYTES_W*BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic [ADD_W-1:0] fifo_num_bytes;
  logic fifo_in_valid;
  logic [DATA_IN_BYTES_W*BYTE_W-1:0] fifo_in_data;
  logic [NUM_BYTES_IN_W-1:0] fifo_num_bytes_in;
  logic [REQ_ID_W-1:0] fifo_in_id;
  modport master (
    input req_valid, req_last, req_bytes, req_data, fifo_num_bytes,
    output req_ready, fifo_in_valid, fifo_in_data, fifo_num_bytes_in, fifo_in_id
  );
  modport slave (
    output req_valid, req_last, req_bytes, req_data, fifo_num_bytes,
    input req_ready, fifo_in_valid, fifo_in_data, fifo_num_bytes_in, fifo_in_id
  );
endinterface

// File: rtl/byte_fifo_rr_pick.sv
// byte_fifo_rr_pick: first valid requester at or after rr_ptr, with wrap-around
module byte_fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int REQ_ID_W = 2
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [REQ_ID_W-1:0] rr_ptr,
  output logic [REQ_ID_W-1:0] grant,
  output logic                any_valid
);
  // scan farthest-to-nearest so the nearest valid requester is written last
  always_comb begin
    grant = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(32'(rr_ptr) + k) % NUM_REQ]) grant = REQ_ID_W'((32'(rr_ptr) + k) % NUM_REQ);
    any_valid = |req_valid;
  end
endmodule

// File: rtl/byte_fifo_wr_arb.sv
// byte_fifo_wr_arb: round-robin, packet-locked arbiter for the byte_fifo write port
// Beats are forwarded through a registered stage only when the FIFO has guaranteed room.
module byte_fifo_wr_arb import byte_fifo_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_IN_BYTES_W = 16,
  parameter int FIFO_BYTE_W = 32,
  parameter int NUM_BYTES_IN_W = clog2w(DATA_IN_BYTES_W + 1),
  parameter int ADD_W = clog2w(FIFO_BYTE_W + 1),
  parameter int REQ_ID_W = clog2w(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sync_rst,
  byte_fifo_wr_arb_if.master  bus,
  output logic                err_len
);
  localparam int DW = DATA_IN_BYTES_W * BYTE_W;
  arb_state_e state_q, state_d;
  logic [REQ_ID_W-1:0] rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d, id_q, id_d, pick_id, g, rr_next;
  logic [NUM_BYTES_IN_W-1:0] nbytes_q, nbytes_d, g_bytes;
  logic [DW-1:0] data_q, data_d, g_data;
  logic [ADD_W:0] used, free;
  logic valid_q, valid_d, err_q, err_d;
  logic any_valid, grant_active, fits, xfer, good, done;

  byte_fifo_rr_pick #(.NUM_REQ(NUM_REQ), .REQ_ID_W(REQ_ID_W)) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_id),
    .any_valid (any_valid)
  );

  always_comb begin
    g = (state_q == LOCKED) ? lock_id_q : pick_id;
    grant_active = (state_q == LOCKED) ? bus.req_valid[lock_id_q] : any_valid;
    g_bytes = bus.req_bytes[g*NUM_BYTES_IN_W +: NUM_BYTES_IN_W];
    g_data = bus.req_data[g*DW +: DW];
    // the beat still sitting in the output stage counts as occupied; drain is ignored
    used = (ADD_W+1)'(bus.fifo_num_bytes) + (valid_q ? (ADD_W+1)'(nbytes_q) : '0);
    free = (used >= (ADD_W+1)'(FIFO_BYTE_W)) ? '0 : (ADD_W+1)'(FIFO_BYTE_W) - used;
    fits = (ADD_W+1)'(g_bytes) <= free;
    xfer = grant_active & fits & ~sync_rst;
    good = (g_bytes != '0) && (32'(g_bytes) <= DATA_IN_BYTES_W);
    done = xfer & bus.req_last[g];
    rr_next = (32'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
    bus.req_ready = xfer ? NUM_REQ'(1) << g : '0;
    state_d = (sync_rst || done) ? IDLE : grant_active ? LOCKED : state_q;
    rr_ptr_d = sync_rst ? '0 : done ? rr_next : rr_ptr_q;
    lock_id_d = sync_rst ? '0 : grant_active ? g : lock_id_q;
    valid_d = xfer & good;
    data_d = sync_rst ? '0 : (xfer & good) ? g_data : data_q;
    nbytes_d = sync_rst ? '0 : (xfer & good) ? g_bytes : nbytes_q;
    id_d = sync_rst ? '0 : (xfer & good) ? g : id_q;
    err_d = ~sync_rst & (err_q | (xfer & (32'(g_bytes) > DATA_IN_BYTES_W)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      lock_id_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      nbytes_q <= '0;
      id_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      valid_q <= valid_d;
      data_q <= data_d;
      nbytes_q <= nbytes_d;
      id_q <= id_d;
      err_q <= err_d;
    end
  end

  assign bus.fifo_in_valid = valid_q;
  assign bus.fifo_in_data = data_q;
  assign bus.fifo_num_bytes_in = nbytes_q;
  assign bus.fifo_in_id = id_q;
  assign err_len = err_q;
endmodule

// File: tb/tb_byte_fifo_wr_arb.sv
// tb_byte_fifo_wr_arb: directed and randomized checks against a packet-level reference model
module tb_byte_fifo_wr_arb;
  localparam int N = 4, DB = 16, FB = 32, NBW = 5, AW = 6, IW = 2, DW = DB * 8;

  logic clk = 1'b0, rst = 1'b1, sync_rst = 1'b0, err_len;
  int n_chk = 0, n_fail = 0;

  // requester-side beats held by the bench until accepted
  logic [N-1:0] v = '0, l = '0;
  int b[N], nb[N];
  logic [DW-1:0] d[N];
  int fnb = 0, xfer_id;
  bit rand_bytes = 0;

  // reference model: owner (-1 = free), pointer and the expected output stage
  int m_owner, m_ptr, m_ob, m_oid;
  bit m_ov, m_err;
  logic [DW-1:0] m_od;

  byte_fifo_wr_arb_if #(.NUM_REQ(N), .DATA_IN_BYTES_W(DB), .FIFO_BYTE_W(FB)) bus ();

  byte_fifo_wr_arb #(.NUM_REQ(N), .DATA_IN_BYTES_W(DB), .FIFO_BYTE_W(FB)) dut (
    .clk(clk), .rst(rst), .sync_rst(sync_rst), .bus(bus), .err_len(err_len)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_ov = 0; m_od = '0; m_ob = 0; m_oid = 0; m_err = 0;
  endtask

  task automatic start(input int i, input int beats, input int bytes);
    nb[i] = beats; v[i] = 1'b1; l[i] = (beats == 1); b[i] = bytes; d[i] = rnd_data();
  endtask

  task automatic drop_all();
    for (int i = 0; i < N; i++) begin v[i] = 1'b0; l[i] = 1'b0; nb[i] = 0; b[i] = 0; end
  endtask

  task automatic expect_bit(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL %s got %b expected %b", tag, got, exp); end
  endtask

  // one clock: drive, predict ready, step the model, then check the registered outputs
  task automatic cycle(input string tag);
    logic [N-1:0] er;
    int fr, cand;
    for (int i = 0; i < N; i++) begin
      bus.req_bytes[i*NBW +: NBW] = NBW'(b[i]);
      bus.req_data[i*DW +: DW] = d[i];
    end
    bus.req_valid = v; bus.req_last = l; bus.fifo_num_bytes = AW'(fnb);
    #1;
    fr = FB - fnb - (m_ov ? m_ob : 0);
    if (fr < 0) fr = 0;
    cand = m_owner;
    if (cand < 0)
      for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) begin cand = (m_ptr + k) % N; break; end
    er = '0; xfer_id = -1;
    if (cand >= 0 && v[cand] && b[cand] <= fr && !sync_rst) begin er[cand] = 1'b1; xfer_id = cand; end
    n_chk++;
    if (bus.req_ready !== er) begin n_fail++; $display("FAIL %s req_ready got %b expected %b", tag, bus.req_ready, er); end
    if (sync_rst) model_reset();
    else begin
      m_ov = 0;
      if (xfer_id >= 0) begin
        if (b[cand] >= 1 && b[cand] <= DB) begin m_ov = 1; m_od = d[cand]; m_ob = b[cand]; m_oid = cand; end
        if (b[cand] > DB) m_err = 1;
        if (l[cand]) begin m_owner = -1; m_ptr = (cand + 1) % N; end else m_owner = cand;
      end else if (cand >= 0) m_owner = cand;
    end
    @(posedge clk); #1;
    expect_bit({tag, " fifo_in_valid"}, bus.fifo_in_valid, m_ov);
    expect_bit({tag, " err_len"}, err_len, m_err);
    n_chk++;
    if (bus.fifo_in_data !== m_od) begin n_fail++; $display("FAIL %s fifo_in_data got %h expected %h", tag, bus.fifo_in_data, m_od); end
    n_chk++;
    if (bus.fifo_num_bytes_in !== NBW'(m_ob)) begin n_fail++; $display("FAIL %s fifo_num_bytes_in got %0d expected %0d", tag, bus.fifo_num_bytes_in, m_ob); end
    n_chk++;
    if (bus.fifo_in_id !== IW'(m_oid)) begin n_fail++; $display("FAIL %s fifo_in_id got %0d expected %0d", tag, bus.fifo_in_id, m_oid); end
    if (xfer_id >= 0) begin
      nb[xfer_id]--;
      if (nb[xfer_id] == 0) begin v[xfer_id] = 1'b0; l[xfer_id] = 1'b0; end
      else begin
        l[xfer_id] = (nb[xfer_id] == 1); d[xfer_id] = rnd_data();
        if (rand_bytes) b[xfer_id] = $urandom_range(0, DB + 2);
      end
    end
  endtask

  task automatic clear();
    drop_all(); fnb = 0; sync_rst = 1'b1;
    cycle("sync_clear");
    sync_rst = 1'b0;
  endtask

  task automatic run(input string tag, input int budget);
    int c = 0;
    while (v != '0 && c < budget) begin cycle(tag); c++; end
    n_chk++;
    if (v != '0) begin n_fail++; $display("FAIL %s drain timeout pending %b expected 0000", tag, v); drop_all(); end
  endtask

  task automatic test_reset();
    drop_all();
    for (int i = 0; i < N; i++) d[i] = '0;
    bus.req_valid = '0; bus.req_last = '0; bus.req_bytes = '0; bus.req_data = '0; bus.fifo_num_bytes = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    expect_bit("reset fifo_in_valid", bus.fifo_in_valid, 1'b0);
    expect_bit("reset err_len", err_len, 1'b0);
    n_chk++;
    if (bus.fifo_in_data !== '0 || bus.fifo_num_bytes_in !== '0 || bus.fifo_in_id !== '0 || bus.req_ready !== '0) begin
      n_fail++; $display("FAIL reset outputs got %h/%0d/%0d/%b expected zero", bus.fifo_in_data, bus.fifo_num_bytes_in, bus.fifo_in_id, bus.req_ready);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fit_stall();
    clear(); start(0, 4, 16);
    cycle("fit_b1"); cycle("fit_b2");
    fnb = 32; cycle("fit_stall");
    expect_bit("fit_stall no beat", bus.fifo_in_valid, 1'b0);
    fnb = 16; cycle("fit_release");
    expect_bit("fit_release beat", bus.fifo_in_valid, 1'b1);
    run("fit_tail", 10);
  endtask

  task automatic test_round_robin();
    clear(); start(0, 1, 8); start(2, 1, 8);
    cycle("rr_a"); expect_bit("rr_a id0", bus.fifo_in_id == 2'd0, 1'b1);
    cycle("rr_b"); expect_bit("rr_b id2", bus.fifo_in_id == 2'd2, 1'b1);
    start(0, 1, 8); cycle("rr_wrap"); expect_bit("rr_wrap id0", bus.fifo_in_id == 2'd0, 1'b1);
    start(0, 1, 8); start(1, 1, 8); cycle("rr_next"); expect_bit("rr_next id1", bus.fifo_in_id == 2'd1, 1'b1);
    run("rr_tail", 10);
  endtask

  task automatic test_lock();
    clear(); start(1, 3, 4);
    cycle("lock_b1"); start(0, 1, 4);
    cycle("lock_b2"); expect_bit("lock req0 blocked", bus.req_ready[0], 1'b0);
    cycle("lock_b3");
    cycle("lock_req0"); expect_bit("lock req0 granted", bus.fifo_in_valid && bus.fifo_in_id == 2'd0, 1'b1);
    run("lock_tail", 10);
  endtask

  task automatic test_full_boundary();
    clear(); fnb = 30; start(3, 1, 4);
    cycle("full_stall"); expect_bit("full_stall no beat", bus.fifo_in_valid, 1'b0);
    start(0, 1, 4); fnb = 28;
    cycle("full_accept");
    expect_bit("full_accept bytes4", bus.fifo_num_bytes_in == 5'd4, 1'b1);
    expect_bit("full_accept id3", bus.fifo_in_id == 2'd3, 1'b1);
    run("full_tail", 10);
  endtask

  task automatic test_zero_oversize();
    clear(); start(2, 1, 0);
    cycle("zero"); expect_bit("zero no beat", bus.fifo_in_valid, 1'b0);
    start(2, 1, 17);
    cycle("over"); expect_bit("over err_len", err_len, 1'b1);
    expect_bit("over no beat", bus.fifo_in_valid, 1'b0);
    cycle("over_hold"); expect_bit("over_hold err_len", err_len, 1'b1);
    clear(); expect_bit("over cleared err_len", err_len, 1'b0);
  endtask

  task automatic test_reset_mid();
    clear(); start(1, 3, 4);
    cycle("mid_b1");
    sync_rst = 1'b1; cycle("mid_sync"); sync_rst = 1'b0;
    expect_bit("mid_sync valid", bus.fifo_in_valid, 1'b0);
    expect_bit("mid_sync err", err_len, 1'b0);
    start(0, 1, 4);
    cycle("mid_after"); expect_bit("mid_after ptr0 id0", bus.fifo_in_id == 2'd0 && bus.fifo_in_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    expect_bit("async valid", bus.fifo_in_valid, 1'b0);
    n_chk++;
    if (bus.fifo_in_data !== '0 || bus.fifo_num_bytes_in !== '0 || bus.fifo_in_id !== '0) begin
      n_fail++; $display("FAIL async outputs got %h/%0d/%0d expected zero", bus.fifo_in_data, bus.fifo_num_bytes_in, bus.fifo_in_id);
    end
    @(posedge clk); #2 rst = 1'b0;
    model_reset(); drop_all();
    start(2, 2, 5); start(3, 1, 6);
    run("async_tail", 10);
  endtask

  task automatic test_random();
    clear(); rand_bytes = 1;
    repeat (600) begin
      for (int i = 0; i < N; i++)
        if (nb[i] == 0 && $urandom_range(0, 2) == 0) start(i, $urandom_range(1, 4), $urandom_range(0, DB + 2));
      fnb = $urandom_range(0, FB);
      sync_rst = ($urandom_range(0, 63) == 0);
      cycle("rand");
    end
    sync_rst = 1'b0; fnb = 0;
    run("rand_tail", 40);
    rand_bytes = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fit_stall();
    test_round_robin();
    test_lock();
    test_full_boundary();
    test_zero_oversize();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
